// File: rtl/draw_scheduler.sv
// Command FIFO and job sequencer for the fill-screen and circle engines.
// Runs one engine job at a time and muxes the active engine onto the VGA pixel port.
module draw_scheduler #(
    parameter int unsigned DEPTH          = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_colour,
    input  logic [7:0]               cmd_cx,
    input  logic [6:0]               cmd_cy,
    input  logic [7:0]               cmd_r,
    input  logic                     clear_req,
    output logic                     fill_start,
    input  logic                     fill_done,
    input  logic [7:0]               fill_x,
    input  logic [6:0]               fill_y,
    input  logic [2:0]               fill_colour,
    input  logic                     fill_plot,
    output logic                     circ_start,
    input  logic                     circ_done,
    output logic [2:0]               circ_colour,
    output logic [7:0]               circ_cx,
    output logic [6:0]               circ_cy,
    output logic [7:0]               circ_r,
    input  logic [7:0]               circ_x,
    input  logic [6:0]               circ_y,
    input  logic [2:0]               circ_vcolour,
    input  logic                     circ_plot,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [2:0]               vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 26;

    typedef enum logic [2:0] {
        IDLE, LOAD, CLR_RUN, CLR_ACK, CIRC_RUN, CIRC_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            clear_req_q, clear_req_d;
    logic            clear_pend_q, clear_pend_d;
    logic [2:0]      circ_colour_q, circ_colour_d;
    logic [7:0]      circ_cx_q, circ_cx_d;
    logic [6:0]      circ_cy_q, circ_cy_d;
    logic [7:0]      circ_r_q, circ_r_d;
    logic            clr_take;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;

    // State register and datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            clear_req_q   <= 1'b0;
            clear_pend_q  <= CLEAR_ON_RESET;
            circ_colour_q <= '0;
            circ_cx_q     <= '0;
            circ_cy_q     <= '0;
            circ_r_q      <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            clear_req_q   <= clear_req_d;
            clear_pend_q  <= clear_pend_d;
            circ_colour_q <= circ_colour_d;
            circ_cx_q     <= circ_cx_d;
            circ_cy_q     <= circ_cy_d;
            circ_r_q      <= circ_r_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Next-state logic; a pending clear wins over queued circles
    always_comb begin
        state_d  = state_q;
        clr_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_pend_q) begin
                    state_d  = CLR_RUN;
                    clr_take = 1'b1;
                end else if (count_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD:     state_d = CIRC_RUN;
            CLR_RUN:  if (fill_done)  state_d = CLR_ACK;
            CLR_ACK:  if (!fill_done) state_d = IDLE;
            CIRC_RUN: if (circ_done)  state_d = CIRC_ACK;
            CIRC_ACK: if (!circ_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FIFO, clear tracking and job parameter registers
    always_comb begin
        push          = cmd_valid && cmd_ready;
        pop           = (state_q == LOAD);
        head          = mem_q[rd_ptr_q];
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        circ_colour_d = circ_colour_q;
        circ_cx_d     = circ_cx_q;
        circ_cy_d     = circ_cy_q;
        circ_r_d      = circ_r_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_colour, cmd_cx, cmd_cy, cmd_r};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + AW'(1);
            circ_colour_d = head[25:23];
            circ_cx_d     = head[22:15];
            circ_cy_d     = head[14:8];
            circ_r_d      = head[7:0];
        end
        count_d = count_q + CW'(push) - CW'(pop);
        // The request is registered once, so a new pulse arriving during a clear re-arms it
        clear_req_d  = clear_req;
        clear_pend_d = clear_req_q || (clear_pend_q && !clr_take);
    end

    // Engine starts, pixel mux and status outputs from current state
    always_comb begin
        fill_start = 1'b0;
        circ_start = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        case (state_q)
            CLR_RUN: begin
                fill_start = 1'b1;
                vga_x      = fill_x;
                vga_y      = fill_y;
                vga_colour = fill_colour;
                vga_plot   = fill_plot;
            end
            CIRC_RUN: begin
                circ_start = 1'b1;
                vga_x      = circ_x;
                vga_y      = circ_y;
                vga_colour = circ_vcolour;
                vga_plot   = circ_plot;
            end
            default: ;
        endcase
        busy      = (state_q != IDLE);
        cmd_ready = (count_q < CW'(DEPTH));
    end

    assign count       = count_q;
    assign circ_colour = circ_colour_q;
    assign circ_cx     = circ_cx_q;
    assign circ_cy     = circ_cy_q;
    assign circ_r      = circ_r_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with behavioural fill and circle engine models.
`timescale 1ns/1ps
module tb_draw_scheduler;

    localparam int FILL_LAT = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_colour;
    logic [7:0] cmd_cx;
    logic [6:0] cmd_cy;
    logic [7:0] cmd_r;
    logic       clear_req;
    logic       fill_start, fill_done;
    logic [7:0] fill_x;
    logic [6:0] fill_y;
    logic [2:0] fill_colour;
    logic       fill_plot;
    logic       circ_start, circ_done;
    logic [2:0] circ_colour;
    logic [7:0] circ_cx;
    logic [6:0] circ_cy;
    logic [7:0] circ_r;
    logic [7:0] circ_x;
    logic [6:0] circ_y;
    logic [2:0] circ_vcolour;
    logic       circ_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;
    int circ_lat = 20;
    logic [7:0] fcnt, ccnt;
    int   log_q[$];
    logic fill_prev, circ_prev;
    logic [7:0] run_r;

    int exp2[3] = '{10, 20, 30};
    int exp3[6] = '{41, 42, 43, 44, 45, 46};
    int exp4[3] = '{0, 51, 52};

    draw_scheduler #(.DEPTH(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_colour(cmd_colour), .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_r(cmd_r),
        .clear_req(clear_req),
        .fill_start(fill_start), .fill_done(fill_done),
        .fill_x(fill_x), .fill_y(fill_y), .fill_colour(fill_colour), .fill_plot(fill_plot),
        .circ_start(circ_start), .circ_done(circ_done),
        .circ_colour(circ_colour), .circ_cx(circ_cx), .circ_cy(circ_cy), .circ_r(circ_r),
        .circ_x(circ_x), .circ_y(circ_y), .circ_vcolour(circ_vcolour), .circ_plot(circ_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    // Fill engine: done after FILL_LAT cycles of start, held until start falls
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= 8'd0; fill_done <= 1'b0;
        end else if (fill_start && !fill_done) begin
            if (fcnt == 8'(FILL_LAT - 1)) fill_done <= 1'b1;
            fcnt <= fcnt + 8'd1;
        end else if (!fill_start) begin
            fcnt <= 8'd0; fill_done <= 1'b0;
        end
    end
    assign fill_plot   = fill_start && !fill_done;
    assign fill_x      = fcnt;
    assign fill_y      = 7'd5;
    assign fill_colour = 3'd7;

    // Circle engine with programmable latency
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ccnt <= 8'd0; circ_done <= 1'b0;
        end else if (circ_start && !circ_done) begin
            if (ccnt == 8'(circ_lat - 1)) circ_done <= 1'b1;
            ccnt <= ccnt + 8'd1;
        end else if (!circ_start) begin
            ccnt <= 8'd0; circ_done <= 1'b0;
        end
    end
    assign circ_plot    = circ_start && !circ_done;
    assign circ_x       = ccnt;
    assign circ_y       = 7'd9;
    assign circ_vcolour = 3'd2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Job log: 0 marks a clear, otherwise the radius of a started circle
    always @(negedge clk) begin
        if (rst) begin
            fill_prev = 1'b0; circ_prev = 1'b0;
        end else begin
            if (fill_start && !fill_prev) log_q.push_back(0);
            if (circ_start && !circ_prev) begin
                log_q.push_back(int'(circ_r));
                run_r = circ_r;
            end else if (circ_start) begin
                chk("circ_r_stable", 32'(circ_r), 32'(run_r));
            end
            fill_prev = fill_start;
            circ_prev = circ_start;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input string tag, input int max);
        int n = 0;
        int q = 0;
        while (q < 4 && n < max) begin
            step(1);
            n++;
            if (busy === 1'b0 && count === 3'd0) q++; else q = 0;
        end
        chk(tag, 32'(n < max), 1);
    endtask

    task automatic drive_cmd(input logic [2:0] c, input logic [7:0] r);
        cmd_valid = 1'b1; cmd_colour = c; cmd_cx = 8'd80; cmd_cy = 7'd60; cmd_r = r;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_colour = '0; cmd_cx = '0; cmd_cy = '0; cmd_r = '0;
        clear_req = 1'b0;
        step(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_fill_start", 32'(fill_start), 0);
        chk("rst_circ_start", 32'(circ_start), 0);
        chk("rst_vga_plot", 32'(vga_plot), 0);
        chk("rst_circ_r", 32'(circ_r), 0);

        // Clear pending out of reset
        rst = 1'b0;
        step(1);
        chk("por_fill_start", 32'(fill_start), 1);
        chk("por_busy", 32'(busy), 1);
        chk("por_vga_plot", 32'(vga_plot), 1);
        step(1);
        chk("por_vga_x", 32'(vga_x), 1);
        chk("por_vga_y", 32'(vga_y), 5);
        chk("por_vga_colour", 32'(vga_colour), 7);
        step(9);
        chk("por_fill_done", 32'(fill_done), 1);
        chk("por_start_held", 32'(fill_start), 1);
        chk("por_plot_off", 32'(vga_plot), 0);
        step(1);
        chk("por_start_drop", 32'(fill_start), 0);
        chk("por_ack_busy", 32'(busy), 1);
        chk("por_ack_vga_x", 32'(vga_x), 0);
        step(2);
        chk("por_idle", 32'(busy), 0);

        // Three back-to-back circles
        log_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive_cmd(3'(i + 1), 8'(10 * (i + 1)));
            step(1);
            chk("b2b_count", 32'(count), (i == 0) ? 1 : 2);
        end
        cmd_valid = 1'b0;
        chk("b2b_circ_start", 32'(circ_start), 1);
        chk("b2b_circ_colour", 32'(circ_colour), 1);
        chk("b2b_circ_cx", 32'(circ_cx), 80);
        chk("b2b_circ_cy", 32'(circ_cy), 60);
        chk("b2b_circ_r", 32'(circ_r), 10);
        step(1);
        chk("b2b_vga_x", 32'(vga_x), 1);
        chk("b2b_vga_y", 32'(vga_y), 9);
        chk("b2b_vga_colour", 32'(vga_colour), 2);
        wait_quiet("b2b_timeout", 400);
        chk("b2b_log_size", 32'(log_q.size()), 3);
        for (int i = 0; i < 3; i++) chk("b2b_order", 32'(log_q[i]), 32'(exp2[i]));
        chk("b2b_hold_r", 32'(circ_r), 30);
        chk("b2b_hold_colour", 32'(circ_colour), 3);

        // Fill the FIFO behind a long job; a held push waits for a pop
        circ_lat = 60;
        log_q.delete();
        for (int i = 0; i < 5; i++) begin
            drive_cmd(3'd4, 8'(41 + i));
            step(1);
            chk("full_count", 32'(count), (i < 3) ? ((i == 0) ? 1 : 2) : i);
        end
        chk("full_ready", 32'(cmd_ready), 0);
        drive_cmd(3'd5, 8'd46);
        step(3);
        chk("full_hold_count", 32'(count), 4);
        chk("full_hold_ready", 32'(cmd_ready), 0);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin step(1); n++; end
        chk("full_wait", 32'(n < 200), 1);
        chk("full_pop_count", 32'(count), 3);
        step(1);
        cmd_valid = 1'b0;
        chk("full_refill_count", 32'(count), 4);
        wait_quiet("full_timeout", 1000);
        chk("full_log_size", 32'(log_q.size()), 6);
        for (int i = 0; i < 6; i++) chk("full_order", 32'(log_q[i]), 32'(exp3[i]));

        // Clear requested just ahead of two queued circles
        circ_lat = 20;
        log_q.delete();
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        drive_cmd(3'd1, 8'd51);
        step(1);
        chk("prio_fill_wait", 32'(fill_start), 0);
        drive_cmd(3'd1, 8'd52);
        step(1);
        cmd_valid = 1'b0;
        chk("prio_fill_start", 32'(fill_start), 1);
        chk("prio_count", 32'(count), 2);
        wait_quiet("prio_timeout", 400);
        chk("prio_log_size", 32'(log_q.size()), 3);
        for (int i = 0; i < 3; i++) chk("prio_order", 32'(log_q[i]), 32'(exp4[i]));

        // Two requests during a clear collapse into one more clear
        log_q.delete();
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        step(1);
        chk("clr_latency_low", 32'(fill_start), 0);
        step(1);
        chk("clr_latency_high", 32'(fill_start), 1);
        step(2);
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        step(2);
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        wait_quiet("clr_timeout", 200);
        chk("clr_log_size", 32'(log_q.size()), 2);
        chk("clr_second", 32'(log_q[1]), 0);

        // Reset in the middle of a circle with two commands queued
        circ_lat = 60;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(3'd6, 8'(61 + i));
            step(1);
        end
        cmd_valid = 1'b0;
        step(5);
        chk("mid_circ_start", 32'(circ_start), 1);
        chk("mid_circ_r", 32'(circ_r), 61);
        chk("mid_count", 32'(count), 2);
        log_q.delete();
        rst = 1'b1;
        #1;
        chk("mid_rst_circ_start", 32'(circ_start), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_vga_plot", 32'(vga_plot), 0);
        chk("mid_rst_circ_r", 32'(circ_r), 0);
        step(2);
        rst = 1'b0;
        wait_quiet("mid_timeout", 200);
        chk("mid_log_size", 32'(log_q.size()), 1);
        chk("mid_only_clear", 32'(log_q[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
